// File: rtl/pkt_dispatch_ctrl.sv
// pkt_dispatch_ctrl: queues packet headers and dispatches each one through its
// processing units, tracking done handshakes with timeout recovery.
module pkt_dispatch_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int ID_WIDTH   = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                newpkt,
    input  logic [2:0]          fPktType,
    input  logic [ID_WIDTH-1:0] destinationID,
    input  logic [ID_WIDTH-1:0] myNodeID,
    output logic                fifo_full,
    output logic                en_MNI,
    output logic                en_KCH,
    output logic                en_QTU,
    output logic                en_reward,
    input  logic                done_MNI,
    input  logic                done_KCH,
    input  logic                done_QTU,
    input  logic                done_reward,
    output logic                iAmDestination,
    output logic [2:0]          curPktType,
    output logic                busy,
    output logic                pkt_done,
    output logic                timeout_err,
    output logic [7:0]          drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE1, S_WAIT1, S_ISSUE2, S_WAIT2, S_FIN} state_t;
    state_t r_state, w_next;
    logic [ID_WIDTH+2:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0] r_cnt;
    logic [3:0] r_pend, w_pend_nx, w_done;
    logic [7:0] r_timer;
    logic [2:0] w_p1, w_head_type;
    logic w_push, w_pop, w_rew, w_wait;

    assign fifo_full   = r_cnt == (AW+1)'(FIFO_DEPTH);
    assign w_push      = newpkt && !fifo_full;
    assign w_pop       = r_state == S_IDLE && r_cnt != '0;
    assign w_head_type = r_mem[r_rptr][ID_WIDTH+:3];
    assign w_done      = {done_reward, done_QTU, done_KCH, done_MNI};
    assign w_pend_nx   = r_pend & ~w_done;
    assign w_wait      = r_state == S_WAIT1 || r_state == S_WAIT2;
    assign busy        = r_state != S_IDLE;
    // phase-1 unit mask as {QTU, KCH, MNI}
    assign w_p1 = (curPktType == 3'b000 || curPktType == 3'b100) ? 3'b001 :
                  curPktType == 3'b001 ? 3'b011 :
                  curPktType == 3'b010 ? 3'b010 :
                  curPktType == 3'b111 ? 3'b000 : 3'b100;
    assign w_rew = curPktType inside {3'b000, 3'b010, 3'b011, 3'b100} ||
                   (curPktType inside {3'b101, 3'b110} && iAmDestination);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {fPktType, destinationID};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state        <= S_IDLE;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_cnt          <= '0;
            r_pend         <= '0;
            r_timer        <= '0;
            curPktType     <= '0;
            iAmDestination <= 1'b0;
            drop_cnt       <= '0;
        end else begin
            r_state <= w_next;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr         <= r_rptr + 1'b1;
                curPktType     <= w_head_type;
                iAmDestination <= r_mem[r_rptr][ID_WIDTH-1:0] == myNodeID;
            end
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (newpkt && fifo_full && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
            r_timer <= w_wait ? r_timer + 1'b1 : '0;
            r_pend  <= r_state == S_ISSUE1 ? {1'b0, w_p1} : r_state == S_ISSUE2 ? 4'b1000 : w_pend_nx;
        end
    end

    always_comb begin
        w_next      = r_state;
        en_MNI      = 1'b0;
        en_KCH      = 1'b0;
        en_QTU      = 1'b0;
        en_reward   = 1'b0;
        pkt_done    = 1'b0;
        timeout_err = 1'b0;
        case (r_state)
            S_IDLE:   if (w_pop) w_next = w_head_type == 3'b111 ? S_FIN : S_ISSUE1;
            S_ISSUE1: begin
                {en_QTU, en_KCH, en_MNI} = w_p1;
                w_next = S_WAIT1;
            end
            S_WAIT1, S_WAIT2: begin
                // a done landing in the timeout cycle wins over the abort
                if (w_pend_nx == '0) w_next = (r_state == S_WAIT1 && w_rew) ? S_ISSUE2 : S_FIN;
                else if (r_timer == 8'(TIMEOUT)) begin
                    timeout_err = 1'b1;
                    w_next      = S_FIN;
                end
            end
            S_ISSUE2: begin
                en_reward = 1'b1;
                w_next    = S_WAIT2;
            end
            S_FIN: begin
                pkt_done = 1'b1;
                w_next   = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_pkt_dispatch_ctrl.sv
// tb_pkt_dispatch_ctrl: directed checks of dispatch order, latency, FIFO
// overflow, timeout recovery and async reset.
module tb_pkt_dispatch_ctrl;
    logic clk = 1'b0, nrst = 1'b0, newpkt = 1'b0;
    logic [2:0] fPktType = '0;
    logic [15:0] destinationID = '0, myNodeID = 16'h0005;
    logic done_MNI = 1'b0, done_KCH = 1'b0, done_QTU = 1'b0, done_reward = 1'b0;
    logic fifo_full, en_MNI, en_KCH, en_QTU, en_reward, iAmDestination, busy, pkt_done, timeout_err;
    logic [2:0] curPktType;
    logic [7:0] drop_cnt;

    int n_chk = 0, n_pass = 0, cyc = 0;
    int n_mni = 0, n_kch = 0, n_qtu = 0, n_rew = 0, n_done = 0, n_te = 0, viol = 0;
    int at_mni = -1, at_kch = -1, at_qtu = -1, at_rew = -1, at_done = -1, at_te = -1;
    logic [2:0] lg [32];
    int li = 0;
    logic [3:0] prev_en = '0;

    pkt_dispatch_ctrl dut (
        .clk(clk), .nrst(nrst), .newpkt(newpkt), .fPktType(fPktType),
        .destinationID(destinationID), .myNodeID(myNodeID), .fifo_full(fifo_full),
        .en_MNI(en_MNI), .en_KCH(en_KCH), .en_QTU(en_QTU), .en_reward(en_reward),
        .done_MNI(done_MNI), .done_KCH(done_KCH), .done_QTU(done_QTU), .done_reward(done_reward),
        .iAmDestination(iAmDestination), .curPktType(curPktType), .busy(busy),
        .pkt_done(pkt_done), .timeout_err(timeout_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // stamps the cycle of every pulse and logs the type at each phase-1 issue
    always @(negedge clk) begin
        if (en_MNI) begin n_mni <= n_mni + 1; at_mni <= cyc; end
        if (en_KCH) begin n_kch <= n_kch + 1; at_kch <= cyc; end
        if (en_QTU) begin n_qtu <= n_qtu + 1; at_qtu <= cyc; end
        if (en_reward) begin n_rew <= n_rew + 1; at_rew <= cyc; end
        if (pkt_done) begin n_done <= n_done + 1; at_done <= cyc; end
        if (timeout_err) begin n_te <= n_te + 1; at_te <= cyc; end
        if ((en_MNI || en_KCH || en_QTU) && li < 32) begin lg[li] <= curPktType; li <= li + 1; end
        if (({en_reward, en_QTU, en_KCH, en_MNI} & prev_en) != '0) viol <= viol + 1;
        prev_en <= {en_reward, en_QTU, en_KCH, en_MNI};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) nxt();
    endtask

    task automatic send(input logic [2:0] t, input logic [15:0] d);
        newpkt = 1'b1;
        fPktType = t;
        destinationID = d;
        nxt();
        newpkt = 1'b0;
    endtask

    task automatic all_done(input logic v);
        {done_MNI, done_KCH, done_QTU, done_reward} = {4{v}};
    endtask

    int t0, b0, b1, b2, b3;
    logic [2:0] tp [5] = '{3'd0, 3'd4, 3'd2, 3'd3, 3'd1};

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_type", curPktType, 0);
        chk("rst_en", {en_MNI, en_KCH, en_QTU, en_reward, pkt_done, timeout_err}, 0);
        nrst = 1'b1;
        nxt();

        t0 = cyc; b0 = n_mni; b1 = n_kch; b2 = n_rew;
        send(3'd1, 16'h0005);
        wait_to(t0 + 3);
        chk("che_busy", busy, 1);
        chk("che_type", curPktType, 1);
        wait_to(t0 + 4); done_KCH = 1'b1; nxt(); done_KCH = 1'b0;
        wait_to(t0 + 6); done_MNI = 1'b1; nxt(); done_MNI = 1'b0;
        wait_to(t0 + 9);
        chk("che_mni_at", at_mni - t0, 2);
        chk("che_kch_at", at_kch - t0, 2);
        chk("che_mni_n", n_mni - b0, 1);
        chk("che_kch_n", n_kch - b1, 1);
        chk("che_done_at", at_done - t0, 7);
        chk("che_no_rew", n_rew - b2, 0);

        t0 = cyc;
        send(3'd5, 16'h0005);
        wait_to(t0 + 3);
        chk("data_iad1", iAmDestination, 1);
        done_QTU = 1'b1; nxt(); done_QTU = 1'b0;
        wait_to(t0 + 5); done_reward = 1'b1; nxt(); done_reward = 1'b0;
        wait_to(t0 + 8);
        chk("data_qtu_at", at_qtu - t0, 2);
        chk("data_rew_at", at_rew - t0, 4);
        chk("data_done_at", at_done - t0, 6);

        t0 = cyc; b2 = n_rew;
        send(3'd5, 16'h0006);
        wait_to(t0 + 3);
        chk("data_iad0", iAmDestination, 0);
        done_QTU = 1'b1; nxt(); done_QTU = 1'b0;
        wait_to(t0 + 6);
        chk("data_done_at2", at_done - t0, 4);
        chk("data_no_rew", n_rew - b2, 0);

        t0 = cyc; b0 = n_mni + n_kch + n_qtu + n_rew;
        send(3'd7, 16'h0000);
        wait_to(t0 + 4);
        chk("t7_done_at", at_done - t0, 2);
        chk("t7_no_en", n_mni + n_kch + n_qtu + n_rew - b0, 0);
        chk("t7_type", curPktType, 7);

        t0 = cyc; b0 = n_done;
        send(3'd2, 16'h0000);
        wait_to(t0 + 3);
        b1 = li;
        for (int i = 0; i < 5; i++) begin
            newpkt = 1'b1;
            fPktType = tp[i];
            if (i == 4) chk("ovf_full", fifo_full, 1);
            nxt();
        end
        newpkt = 1'b0;
        chk("ovf_drop", drop_cnt, 1);
        all_done(1'b1);
        wait_to(t0 + 50);
        all_done(1'b0);
        chk("ovf_n_issued", li - b1, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("ovf_order%0d", i), lg[b1 + i], tp[i]);
        chk("ovf_n_done", n_done - b0, 5);
        chk("ovf_idle", busy, 0);
        chk("ovf_empty", fifo_full, 0);

        nxt();
        t0 = cyc; b0 = n_te; b1 = n_rew; b2 = n_done;
        send(3'd3, 16'h0000);
        send(3'd0, 16'h0000);
        wait_to(t0 + 257);
        chk("to_early", timeout_err, 0);
        nxt();
        chk("to_pulse", timeout_err, 1);
        nxt();
        chk("to_pkt_done", pkt_done, 1);
        wait_to(t0 + 262);
        all_done(1'b1);
        wait_to(t0 + 270);
        all_done(1'b0);
        chk("to_at", at_te - t0, 258);
        chk("to_n", n_te - b0, 1);
        chk("to_next_mni", at_mni - t0, 261);
        chk("to_next_rew", at_rew - t0, 263);
        chk("to_rew_n", n_rew - b1, 1);
        chk("to_done_n", n_done - b2, 2);

        chk("sat_pre", drop_cnt, 1);
        newpkt = 1'b1;
        fPktType = 3'd3;
        repeat (400) nxt();
        newpkt = 1'b0;
        chk("sat_drop", drop_cnt, 255);
        nxt();
        chk("mid_busy", busy, 1);
        nrst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_full", fifo_full, 0);
        chk("arst_drop", drop_cnt, 0);
        chk("arst_type", curPktType, 0);
        chk("arst_out", {en_MNI, en_KCH, en_QTU, en_reward, pkt_done, timeout_err, iAmDestination}, 0);
        #1 nrst = 1'b1;
        b0 = n_mni + n_kch + n_qtu + n_rew + n_done + n_te;
        repeat (10) nxt();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_quiet", n_mni + n_kch + n_qtu + n_rew + n_done + n_te - b0, 0);
        chk("en_one_cycle", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
